// File: rtl/bank_arbiter_if.sv
// Bundle of requester handshakes and bank-side bus signals for bank_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requesters and models the bank.
interface bank_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 128
) ();

  logic              r0_req;
  logic              r1_req;
  logic              r0_we;
  logic              r1_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic [DATA_W-1:0] r1_wdata;
  logic              r0_gnt;
  logic              r1_gnt;
  logic              r0_done;
  logic              r1_done;
  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] bnk_addr;
  logic              bnk_rw;
  logic              bnk_en;
  logic [DATA_W-1:0] bnk_din;
  logic [DATA_W-1:0] bnk_dout;

  modport slave (
    input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
    input  bnk_dout,
    output r0_gnt, r1_gnt, r0_done, r1_done, rdata,
    output bnk_addr, bnk_rw, bnk_en, bnk_din
  );

  modport master (
    output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
    output bnk_dout,
    input  r0_gnt, r1_gnt, r0_done, r1_done, rdata,
    input  bnk_addr, bnk_rw, bnk_en, bnk_din
  );

endinterface

// File: rtl/bank_arbiter.sv
// Two-requester arbiter for a single-ported bank.
// Reads take one bank-enable cycle; writes are framed by a setup cycle and a
// hold cycle so address/data/direction are stable around the write strobe.
// Grants are issued combinationally while idle (so a held request is taken in
// the very first idle cycle); everything on the bank side is registered.
module bank_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 128
) (
  input logic          clk,
  input logic          rst_n,
  bank_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD        = 3'd1,
    WR_SETUP  = 3'd2,
    WR_STROBE = 3'd3,
    WR_HOLD   = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t            state;
  logic              last_gnt;   // 0 = r0 granted last, 1 = r1 granted last
  logic              owner;      // requester currently being served
  logic              pick1;      // arbitration result: 1 selects r1
  logic              grant_any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Round-robin choice between the two requesters and mux of the winner's fields.
  always_comb begin
    pick1     = 1'b0;
    sel_we    = bus.r0_we;
    sel_addr  = bus.r0_addr;
    sel_wdata = bus.r0_wdata;
    if (bus.r0_req && bus.r1_req) begin
      pick1 = ~last_gnt;
    end else begin
      pick1 = bus.r1_req;
    end
    if (pick1) begin
      sel_we    = bus.r1_we;
      sel_addr  = bus.r1_addr;
      sel_wdata = bus.r1_wdata;
    end
  end

  // Grants only while idle and out of reset; done decodes the response state.
  always_comb begin
    grant_any   = rst_n && (state == IDLE) && (bus.r0_req || bus.r1_req);
    bus.r0_gnt  = grant_any && !pick1;
    bus.r1_gnt  = grant_any && pick1;
    bus.r0_done = (state == RESP) && !owner;
    bus.r1_done = (state == RESP) && owner;
  end

  // Access sequencer: drives the registered bank controls and captures read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_gnt     <= 1'b1;
      owner        <= 1'b0;
      bus.bnk_en   <= 1'b0;
      bus.bnk_rw   <= 1'b1;
      bus.bnk_addr <= '0;
      bus.bnk_din  <= '0;
      bus.rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner        <= pick1;
            last_gnt     <= pick1;
            bus.bnk_addr <= sel_addr;
            if (sel_we) begin
              bus.bnk_din <= sel_wdata;
              bus.bnk_rw  <= 1'b0;
              bus.bnk_en  <= 1'b0;
              state       <= WR_SETUP;
            end else begin
              bus.bnk_rw  <= 1'b1;
              bus.bnk_en  <= 1'b1;
              state       <= RD;
            end
          end
        end
        RD: begin
          bus.rdata  <= bus.bnk_dout;
          bus.bnk_en <= 1'b0;
          state      <= RESP;
        end
        WR_SETUP: begin
          bus.bnk_en <= 1'b1;
          state      <= WR_STROBE;
        end
        WR_STROBE: begin
          bus.bnk_en <= 1'b0;
          state      <= WR_HOLD;
        end
        WR_HOLD: begin
          bus.bnk_rw <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          bus.bnk_en <= 1'b0;
          bus.bnk_rw <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bank_arbiter.sv
// Directed bench for bank_arbiter with a behavioural bank, a reference memory
// and per-requester queues of expected completions.
module tb_bank_arbiter;

  localparam int AW = 9;
  localparam int DW = 128;

  typedef struct {
    logic          we;
    logic [DW-1:0] data;
  } exp_t;

  logic clk;
  logic rst_n;

  int tests_run;
  int fail_count;
  int gnt_count;
  int done_count;

  exp_t          exp_q0[$];
  exp_t          exp_q1[$];
  logic [DW-1:0] ref_mem[512];
  logic [DW-1:0] bank_mem[512];

  bank_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bank_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: combinational read while enabled for read, write on the strobe edge.
  assign bus.bnk_dout = (bus.bnk_en && bus.bnk_rw) ? bank_mem[bus.bnk_addr] : '0;

  always @(posedge clk) begin
    if (bus.bnk_en && !bus.bnk_rw) bank_mem[bus.bnk_addr] <= bus.bnk_din;
  end

  function automatic logic [DW-1:0] pat(input int k);
    return {32'(k), 32'(~k), 32'(k * 3), 32'(k)};
  endfunction

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
      $error("[TB] check %s failed", tag);
    end
  endtask

  // Scoreboard side: every done pops the requester's oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.r0_gnt) gnt_count++;
    if (bus.r1_gnt) gnt_count++;
    if (bus.r0_done) begin
      done_count++;
      if (exp_q0.size() == 0) check_val("r0_done_spurious", DW'(bus.r0_done), '0);
      else begin
        e = exp_q0.pop_front();
        if (!e.we) check_val("r0_rdata", bus.rdata, e.data);
      end
    end
    if (bus.r1_done) begin
      done_count++;
      if (exp_q1.size() == 0) check_val("r1_done_spurious", DW'(bus.r1_done), '0);
      else begin
        e = exp_q1.pop_front();
        if (!e.we) check_val("r1_rdata", bus.rdata, e.data);
      end
    end
  end

  task automatic push_exp(input int r, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    if (we) ref_mem[addr] = data;
    e.we   = we;
    e.data = we ? '0 : ref_mem[addr];
    if (r == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic apply_stimulus(input int r, input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (r == 0) begin
      bus.r0_req = req; bus.r0_we = we; bus.r0_addr = addr; bus.r0_wdata = data;
    end else begin
      bus.r1_req = req; bus.r1_we = we; bus.r1_addr = addr; bus.r1_wdata = data;
    end
  endtask

  task automatic drop_req(input int r);
    if (r == 0) bus.r0_req = 1'b0;
    else bus.r1_req = 1'b0;
  endtask

  task automatic wait_gnt(input int r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (r == 0) ? bus.r0_gnt : bus.r1_gnt;
    end
  endtask

  task automatic wait_done(input int r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (r == 0) ? bus.r0_done : bus.r1_done;
    end
  endtask

  // One complete access: request, wait for grant, release, wait for done.
  task automatic do_access(input int r, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit ok;
    @(posedge clk); #1;
    push_exp(r, we, addr, data);
    apply_stimulus(r, 1'b1, we, addr, data);
    wait_gnt(r, ok);
    check_val("gnt_arrives", DW'(ok), DW'(1));
    @(posedge clk); #1;
    drop_req(r);
    wait_done(r, ok);
    check_val("done_arrives", DW'(ok), DW'(1));
  endtask

  initial begin
    bit            ok;
    int            grants;
    int            g;
    int            next0;
    int            next1;
    logic [DW-1:0] ones;
    logic [DW-1:0] a5;
    logic [DW-1:0] old_val;

    tests_run = 0; fail_count = 0; gnt_count = 0; done_count = 0;
    ones = '1;
    a5   = {16{8'hA5}};
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    rst_n = 1'b0;
    apply_stimulus(0, 1'b0, 1'b0, '0, '0);
    apply_stimulus(1, 1'b0, 1'b0, '0, '0);

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_bnk_en", DW'(bus.bnk_en), '0);
    check_val("rst_bnk_rw", DW'(bus.bnk_rw), DW'(1));
    check_val("rst_bnk_addr", DW'(bus.bnk_addr), '0);
    check_val("rst_bnk_din", bus.bnk_din, '0);
    check_val("rst_rdata", bus.rdata, '0);
    check_val("rst_gnt", DW'({bus.r0_gnt, bus.r1_gnt}), '0);
    check_val("rst_done", DW'({bus.r0_done, bus.r1_done}), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Preload row 0x005 through the arbiter
    do_access(0, 1'b1, 9'h005, a5);

    // Single read with exact latency
    @(posedge clk); #1;
    push_exp(0, 1'b0, 9'h005, '0);
    apply_stimulus(0, 1'b1, 1'b0, 9'h005, '0);
    @(negedge clk);
    check_val("rd_r0_gnt", DW'(bus.r0_gnt), DW'(1));
    check_val("rd_r1_gnt", DW'(bus.r1_gnt), '0);
    @(posedge clk); #1;
    drop_req(0);
    @(negedge clk);
    check_val("rd_bnk_en", DW'(bus.bnk_en), DW'(1));
    check_val("rd_bnk_rw", DW'(bus.bnk_rw), DW'(1));
    check_val("rd_bnk_addr", DW'(bus.bnk_addr), DW'(9'h005));
    check_val("rd_early_done", DW'(bus.r0_done), '0);
    @(negedge clk);
    check_val("rd_done", DW'(bus.r0_done), DW'(1));
    check_val("rd_rdata", bus.rdata, a5);
    check_val("rd_en_off", DW'(bus.bnk_en), '0);

    // Single write with setup/strobe/hold framing
    @(posedge clk); #1;
    push_exp(1, 1'b1, 9'h1FF, ones);
    apply_stimulus(1, 1'b1, 1'b1, 9'h1FF, ones);
    @(negedge clk);
    check_val("wr_r1_gnt", DW'(bus.r1_gnt), DW'(1));
    @(posedge clk); #1;
    drop_req(1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_val("wr_bnk_en", DW'(bus.bnk_en), DW'(i == 2));
      check_val("wr_bnk_rw", DW'(bus.bnk_rw), '0);
      check_val("wr_bnk_addr", DW'(bus.bnk_addr), DW'(9'h1FF));
      check_val("wr_bnk_din", bus.bnk_din, ones);
      check_val("wr_no_done", DW'(bus.r1_done), '0);
    end
    @(negedge clk);
    check_val("wr_done", DW'(bus.r1_done), DW'(1));
    check_val("wr_rdata_kept", bus.rdata, a5);
    check_val("wr_en_off", DW'(bus.bnk_en), '0);
    do_access(0, 1'b0, 9'h1FF, '0);

    // Request arriving during another access waits for idle
    @(posedge clk); #1;
    push_exp(0, 1'b1, 9'h040, pat(7));
    apply_stimulus(0, 1'b1, 1'b1, 9'h040, pat(7));
    @(negedge clk);
    check_val("ign_r0_gnt", DW'(bus.r0_gnt), DW'(1));
    @(posedge clk); #1;
    drop_req(0);
    push_exp(1, 1'b0, 9'h005, '0);
    apply_stimulus(1, 1'b1, 1'b0, 9'h005, '0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check_val("ign_r1_held_off", DW'(bus.r1_gnt), '0);
    end
    check_val("ign_r0_done", DW'(bus.r0_done), DW'(1));
    @(negedge clk);
    check_val("ign_r1_gnt", DW'(bus.r1_gnt), DW'(1));
    @(posedge clk); #1;
    drop_req(1);
    wait_done(1, ok);
    check_val("ign_r1_done", DW'(ok), DW'(1));

    // Full address sweep: write every row, then read them back in order
    for (int k = 0; k < 512; k++) do_access(0, 1'b1, AW'(k), pat(k));
    for (int k = 0; k < 512; k++) do_access(0, 1'b0, AW'(k), '0);

    // Reset during the write strobe aborts the write
    @(posedge clk); #1;
    old_val = ref_mem[9'h033];
    push_exp(0, 1'b1, 9'h033, ones);
    apply_stimulus(0, 1'b1, 1'b1, 9'h033, ones);
    @(negedge clk);
    check_val("abort_r0_gnt", DW'(bus.r0_gnt), DW'(1));
    @(posedge clk); #1;
    drop_req(0);
    apply_stimulus(1, 1'b1, 1'b0, 9'h033, '0);
    @(negedge clk);
    @(negedge clk);
    check_val("abort_strobe_en", DW'(bus.bnk_en), DW'(1));
    #1 rst_n = 1'b0;
    #1;
    check_val("abort_en_drop", DW'(bus.bnk_en), '0);
    void'(exp_q0.pop_back());
    ref_mem[9'h033] = old_val;
    push_exp(1, 1'b0, 9'h033, '0);
    @(negedge clk);
    check_val("abort_no_done", DW'({bus.r0_done, bus.r1_done}), '0);
    check_val("abort_no_gnt", DW'({bus.r0_gnt, bus.r1_gnt}), '0);
    check_val("abort_rdata_clr", bus.rdata, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("abort_regrant", DW'(bus.r1_gnt), DW'(1));
    @(posedge clk); #1;
    drop_req(1);
    wait_done(1, ok);
    check_val("abort_r1_done", DW'(ok), DW'(1));

    // Contention from reset: grants must alternate starting with r0
    @(posedge clk); #1;
    rst_n = 1'b0;
    next0 = 9'h010;
    next1 = 9'h020;
    push_exp(0, 1'b0, AW'(next0), '0);
    push_exp(1, 1'b0, AW'(next1), '0);
    apply_stimulus(0, 1'b1, 1'b0, AW'(next0), '0);
    apply_stimulus(1, 1'b1, 1'b0, AW'(next1), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    gnt_count  = 0;
    done_count = 0;
    grants = 0;
    for (int c = 0; c < 100 && grants < 8; c++) begin
      @(negedge clk);
      if (bus.r0_gnt || bus.r1_gnt) begin
        check_val("cont_onehot", DW'(bus.r0_gnt) + DW'(bus.r1_gnt), DW'(1));
        check_val("cont_order", DW'(bus.r1_gnt), DW'(grants % 2));
        g = bus.r1_gnt ? 1 : 0;
        grants++;
        @(posedge clk); #1;
        if (grants < 8) begin
          if (g == 0) begin
            next0++;
            push_exp(0, 1'b0, AW'(next0), '0);
            apply_stimulus(0, 1'b1, 1'b0, AW'(next0), '0);
          end else begin
            next1++;
            push_exp(1, 1'b0, AW'(next1), '0);
            apply_stimulus(1, 1'b1, 1'b0, AW'(next1), '0);
          end
        end else begin
          drop_req(0);
          drop_req(1);
          if (g == 0) void'(exp_q1.pop_back());
          else void'(exp_q0.pop_back());
        end
      end
    end
    check_val("cont_grants", DW'(grants), DW'(8));
    for (int c = 0; c < 20 && (exp_q0.size() + exp_q1.size()) != 0; c++) @(negedge clk);
    @(negedge clk);
    check_val("cont_q0_empty", DW'(exp_q0.size()), '0);
    check_val("cont_q1_empty", DW'(exp_q1.size()), '0);
    check_val("cont_gnt_done", DW'(done_count), DW'(gnt_count));

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
